digit_serial_adder: RTL and testbench



---
 rtl/digit_serial_pkg.sv | 20 ++
 rtl/cla_slice4.sv | 30 +++
 rtl/digit_serial_adder.sv | 155 +++++++++++++++
 tb/tb_digit_serial_adder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/digit_serial_pkg.sv
// Shared types and helpers for the digit-serial adder: slice width, FSM states
// and the slice-counter width function.
package digit_serial_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    // Counter width for WIDTH/SLICE_W slices, never narrower than one bit
    function automatic int cnt_w(input int width);
        int r;
        r = $clog2(width / SLICE_W);
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/cla_slice4.sv
// Purely combinational 4-bit carry-lookahead slice. All four carries come
// straight from generate/propagate terms; c3 is the carry into bit 3.
module cla_slice4 (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       c3
);

    logic [3:0] g;
    logic [3:0] p;
    logic       c1;
    logic       c2;

    assign g = a & b;
    assign p = a ^ b;

    assign c1   = g[0] | (p[0] & cin);
    assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                | (p[2] & p[1] & p[0] & cin);
    assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                | (p[3] & p[2] & p[1] & g[0])
                | (p[3] & p[2] & p[1] & p[0] & cin);

    assign s = p ^ {c3, c2, c1, cin};

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial WIDTH-bit adder: one 4-bit CLA slice per cycle, LS slice first,
// carry held in carry_q. Define DSA_OVF_EN to add the signed-overflow port ovf.
module digit_serial_adder
    import digit_serial_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef DSA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NSLICE = WIDTH / SLICE_W;
    localparam int CW     = cnt_w(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    state_t state;
    state_t next_state;

    logic [CW-1:0]      slice_cnt;
    logic               in_ready_q;
    logic               out_valid_q;
    logic               busy_q;
    logic               in_ready_d;
    logic               out_valid_d;
    logic               busy_d;

    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic               carry_q;
    logic [WIDTH-1:0]   sum_q;
    logic               cout_q;

    logic [SLICE_W-1:0] s4;
    logic               c4;
    logic               accept;
    logic               last_run;

    assign accept   = in_valid && in_ready_q;
    assign last_run = (state == S_RUN) && (slice_cnt == LAST);

`ifdef DSA_OVF_EN
    logic c3;
    logic ovf_q;

    cla_slice4 u_slice (
        .a    (a_sh[SLICE_W-1:0]),
        .b    (b_sh[SLICE_W-1:0]),
        .cin  (carry_q),
        .s    (s4),
        .cout (c4),
        .c3   (c3)
    );
`else
    cla_slice4 u_slice (
        .a    (a_sh[SLICE_W-1:0]),
        .b    (b_sh[SLICE_W-1:0]),
        .cin  (carry_q),
        .s    (s4),
        .cout (c4),
        .c3   ()
    );
`endif

    // State register; handshake flags are registered so they read 0 in reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            slice_cnt   <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state       <= next_state;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            if (state == S_RUN)
                slice_cnt <= slice_cnt + CW'(1);
            else
                slice_cnt <= '0;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (accept) next_state = S_RUN;
            S_RUN:   if (slice_cnt == LAST) next_state = S_DONE;
            S_DONE:  if (out_ready) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready_d  = (next_state == S_IDLE);
        out_valid_d = (next_state == S_DONE);
        busy_d      = (next_state == S_RUN);
    end

    // Operand/partial-sum shifters: one slice consumed and produced per cycle
    always_ff @(posedge clk) begin
        if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
        end else if (state == S_RUN) begin
            a_sh    <= a_sh >> SLICE_W;
            b_sh    <= b_sh >> SLICE_W;
            sum_sh  <= {s4, sum_sh[WIDTH-1:SLICE_W]};
            carry_q <= c4;
        end
    end

    // Result registers load on the final slice and hold until the next one
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
`ifdef DSA_OVF_EN
            ovf_q  <= 1'b0;
`endif
        end else if (last_run) begin
            sum_q  <= {s4, sum_sh[WIDTH-1:SLICE_W]};
            cout_q <= c4;
`ifdef DSA_OVF_EN
            ovf_q  <= c3 ^ c4;
`endif
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef DSA_OVF_EN
    assign ovf       = ovf_q;
`endif

endmodule

// File: tb/tb_digit_serial_adder.sv
// Directed bench for digit_serial_adder (WIDTH=16); checks ovf when DSA_OVF_EN is defined.
module tb_digit_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        cout;
    logic        busy;
`ifdef DSA_OVF_EN
    logic        ovf;
`endif

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    digit_serial_adder #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .busy      (busy)
`ifdef DSA_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(input string tag, output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid_seen"}, out_valid, 1'b1);
    endtask

    // Single operation with hand-computed expectations, latency and handshake checks
    task automatic do_op(input string tag, input logic [15:0] va, input logic [15:0] vb,
                         input logic vc, input logic [15:0] esum, input logic ecout,
                         input logic eovf);
        int n;
        a = va; b = vb; cin = vc; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_inrdy_low"}, in_ready, 1'b0);
        wait_out(tag, n);
        chk({tag, "_latency"}, n, 4);
        chk({tag, "_sum"}, sum, esum);
        chk({tag, "_cout"}, cout, ecout);
`ifdef DSA_OVF_EN
        chk({tag, "_ovf"}, ovf, eovf);
`else
        if (eovf === 1'bx) $display("unreachable");
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_vld_drop"}, out_valid, 1'b0);
        chk({tag, "_inrdy_back"}, in_ready, 1'b1);
    endtask

    initial begin
        int n;
        int acc_cyc [4];
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic        vc [4];
        logic [16:0] ref_v;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; cin = 1'b0;
        tick(); tick();
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, 16'h0000);
        chk("rst_cout", cout, 1'b0);
        chk("rst_busy", busy, 1'b0);
`ifdef DSA_OVF_EN
        chk("rst_ovf", ovf, 1'b0);
`endif
        #2 rst_n = 1'b1;
        tick();
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Early out_ready must not matter
        out_ready = 1'b1;
        tick();
        chk("early_ordy_no_valid", out_valid, 1'b0);
        out_ready = 1'b0;

        do_op("t1", 16'h0001, 16'h0000, 1'b0, 16'h0001, 1'b0, 1'b0);
        do_op("t2", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        do_op("t3", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        do_op("t4", 16'h000B, 16'h0006, 1'b1, 16'h0012, 1'b0, 1'b0);

        // Back-pressure with new operands pending
        a = 16'h1234; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
        tick();
        a = 16'h8000; b = 16'h8000; cin = 1'b0;
        wait_out("bp", n);
        chk("bp_sum", sum, 16'h2345);
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("bp_hold_valid", out_valid, 1'b1);
            chk("bp_hold_sum", sum, 16'h2345);
            chk("bp_hold_cout", cout, 1'b0);
            chk("bp_hold_inrdy", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("bp_release_inrdy", in_ready, 1'b1);
        chk("bp_release_sum_hold", sum, 16'h2345);
        tick();
        in_valid = 1'b0;
        chk("bp_second_accept", busy, 1'b1);
        wait_out("bp2", n);
        chk("bp2_latency", n, 4);
        chk("bp2_sum", sum, 16'h0000);
        chk("bp2_cout", cout, 1'b1);
`ifdef DSA_OVF_EN
        chk("bp2_ovf", ovf, 1'b1);
`endif
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // Reset during the third slice cycle
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick(); tick();
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_valid", out_valid, 1'b0);
        chk("mid_rst_sum", sum, 16'h0000);
        chk("mid_rst_cout", cout, 1'b0);
        chk("mid_rst_inrdy", in_ready, 1'b0);
        tick(); tick();
        chk("mid_rst_no_emit", out_valid, 1'b0);
        #2 rst_n = 1'b1;
        tick();
        chk("mid_rst_inrdy_back", in_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("mid_rst_still_quiet", out_valid, 1'b0);
        end
        do_op("t5", 16'h0005, 16'h0003, 1'b1, 16'h0009, 1'b0, 1'b0);

        // Back-to-back with in_valid and out_ready held high
        va[0] = 16'h1234; vb[0] = 16'h4321; vc[0] = 1'b0;
        va[1] = 16'hFFFF; vb[1] = 16'hFFFF; vc[1] = 1'b1;
        va[2] = 16'h8000; vb[2] = 16'h7FFF; vc[2] = 1'b1;
        va[3] = 16'h0F0F; vb[3] = 16'hF0F1; vc[3] = 1'b0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = va[i]; b = vb[i]; cin = vc[i];
            n = 0;
            while (in_ready !== 1'b1 && n < 20) begin
                tick();
                n++;
            end
            chk("b2b_ready_seen", in_ready, 1'b1);
            tick();
            acc_cyc[i] = cyc;
            if (i > 0) chk("b2b_interval", acc_cyc[i] - acc_cyc[i-1], 6);
            wait_out("b2b", n);
            ref_v = {1'b0, va[i]} + {1'b0, vb[i]} + {16'h0000, vc[i]};
            chk("b2b_sum", sum, ref_v[15:0]);
            chk("b2b_cout", cout, ref_v[16]);
`ifdef DSA_OVF_EN
            chk("b2b_ovf", ovf, (va[i][15] == vb[i][15]) && (ref_v[15] != va[i][15]));
`endif
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
